// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter in front of the word-only memory interpreter.
// Handles sub-word loads, read-modify-write stores and ack timeouts.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [6:0]  arb_state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        RD_REQ = 7'b0000010,
        RD_REL = 7'b0000100,
        WR_REQ = 7'b0001000,
        WR_REL = 7'b0010000,
        DONE   = 7'b0100000,
        ABORT  = 7'b1000000
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        hold_q, hold_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;

    logic        f_ok, d_ok, pick_d, g_bad;
    logic [31:0] g_addr;
    logic [1:0]  g_size;
    logic [31:0] merged, ext;

    // Round-robin pick; the port just served sits out one idle cycle.
    always_comb begin
        f_ok   = if_req & ~(hold_q & ~last_q);
        d_ok   = d_req & ~(hold_q & last_q);
        pick_d = d_ok & (~f_ok | ~last_q);
        g_addr = pick_d ? d_addr : if_addr;
        g_size = pick_d ? d_size : 2'b10;
        g_bad  = (g_size == 2'b11)
               | ((g_size == 2'b01) & g_addr[0])
               | ((g_size == 2'b10) & (g_addr[1:0] != 2'b00));
    end

    // Replace the addressed byte/half lanes of the word just read.
    always_comb begin
        merged = rword_q;
        if (size_q == 2'b00)
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (off_q[1])
            merged[31:16] = wdata_q;
        else
            merged[15:0] = wdata_q;
    end

    // Extract and extend the addressed lane for data loads.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b   = rword_q[{off_q, 3'b000} +: 8];
        h   = off_q[1] ? rword_q[31:16] : rword_q[15:0];
        ext = rword_q;
        unique case (1'b1)
            size_q == 2'b00: ext = {{24{sgn_q & b[7]}}, b};
            size_q == 2'b01: ext = {{16{sgn_q & h[15]}}, h};
            default:         ext = rword_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        hold_d      = 1'b0;
        err_d       = err_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rword_d     = rword_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        unique case (state_q)
            IDLE: begin
                if (f_ok | d_ok) begin
                    grant_d = pick_d;
                    we_d    = pick_d & d_we;
                    sgn_d   = pick_d & d_signed;
                    size_d  = g_size;
                    off_d   = g_addr[1:0];
                    wdata_d = d_wdata[15:0];
                    err_d   = g_bad;
                    cnt_d   = 8'd0;
                    if (g_bad) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d = {g_addr[31:2], 2'b00};
                        if (pick_d & d_we & (g_size == 2'b10)) begin
                            mem_wdata_d = d_wdata;
                            mem_wen_d   = 1'b1;
                            state_d     = WR_REQ;
                        end else begin
                            mem_ren_d = 1'b1;
                            state_d   = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    rword_d   = mem_rdata;
                    mem_ren_d = 1'b0;
                    state_d   = RD_REL;
                end else if (cnt_q == TO_LAST) begin
                    mem_ren_d = 1'b0;
                    state_d   = ABORT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_REL: begin
                if (!mem_ack) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        mem_wen_d   = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = WR_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    mem_wen_d = 1'b0;
                    state_d   = WR_REL;
                end else if (cnt_q == TO_LAST) begin
                    mem_wen_d = 1'b0;
                    state_d   = ABORT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_REL: begin
                if (!mem_ack)
                    state_d = DONE;
            end
            ABORT: begin
                if (!mem_ack) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                hold_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            hold_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0;
            rword_q     <= 32'h0;
            cnt_q       <= 8'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rword_q     <= rword_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    assign if_done   = (state_q == DONE) & ~grant_q & ~err_q;
    assign if_err    = (state_q == DONE) & ~grant_q & err_q;
    assign d_done    = (state_q == DONE) & grant_q & ~err_q;
    assign d_err     = (state_q == DONE) & grant_q & err_q;
    assign if_rdata  = rword_q;
    assign d_rdata   = ext;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a four-phase interpreter model.
// Pulse code in checks: {if_done, if_err, d_done, d_err}.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [6:0]  arb_state;

    logic        ack_en;
    logic [31:0] mem_word;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          ren_cyc = 0;
    int          wen_cyc = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] wr_word = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_signed(d_signed), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_word;

    // Interpreter model: ack follows request, logs each access.
    always @(posedge clk) begin
        if (rst || !ack_en)
            mem_ack <= 1'b0;
        else
            mem_ack <= mem_ren | mem_wen;
        if (mem_ren) ren_cyc <= ren_cyc + 1;
        if (mem_wen) wen_cyc <= wen_cyc + 1;
        if (ack_en && mem_ren && !mem_ack) begin
            rd_cnt    <= rd_cnt + 1;
            last_addr <= mem_addr;
        end
        if (ack_en && mem_wen && !mem_ack) begin
            wr_cnt    <= wr_cnt + 1;
            wr_word   <= mem_wdata;
            last_addr <= mem_addr;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int bound,
                              output logic [3:0] p,
                              output logic [31:0] ird,
                              output logic [31:0] drd);
        p   = 4'b0;
        ird = 32'h0;
        drd = 32'h0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            p = {if_done, if_err, d_done, d_err};
            if (p != 4'b0) begin
                ird = if_rdata;
                drd = d_rdata;
                break;
            end
        end
    endtask

    task automatic do_d(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [3:0] p,
                        output logic [31:0] drd);
        logic [31:0] ird;
        d_we = we; d_size = sz; d_signed = sg;
        d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_pulse(40, p, ird, drd);
        d_req = 1'b0;
    endtask

    task automatic do_f(input logic [31:0] a,
                        output logic [3:0] p,
                        output logic [31:0] ird);
        logic [31:0] drd;
        if_addr = a; if_req = 1'b1;
        wait_pulse(40, p, ird, drd);
        if_req = 1'b0;
    endtask

    initial begin
        logic [3:0]  p;
        logic [31:0] rd;
        int r0, w0, rc0, wc0;
        bit seen;

        rst = 1'b1; ack_en = 1'b1; mem_word = 32'h0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b10;
        d_signed = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {25'h0, arb_state}, 32'h1);
        chk("rst_pulses", {28'h0, if_done, if_err, d_done, d_err}, 32'h0);
        chk("rst_mem", {30'h0, mem_ren, mem_wen}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_drdata", d_rdata, 32'h0);
        rst = 1'b0;

        mem_word = 32'h3C080013;
        r0 = rd_cnt; wc0 = wen_cyc;
        do_f(32'hBFC00100, p, rd);
        chk("fetch_pulse", {28'h0, p}, 32'h8);
        chk("fetch_rdata", rd, 32'h3C080013);
        chk("fetch_maddr", last_addr, 32'hBFC00100);
        chk("fetch_reads", rd_cnt - r0, 1);
        chk("fetch_nowen", wen_cyc - wc0, 0);
        @(negedge clk);
        chk("fetch_1cyc", {28'h0, if_done, if_err, d_done, d_err}, 32'h0);

        mem_word = 32'h80FF1234;
        do_d(1'b0, 2'b00, 1'b1, 32'h80000013, 32'h0, p, rd);
        chk("lb_pulse", {28'h0, p}, 32'h2);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_maddr", last_addr, 32'h80000010);
        do_d(1'b0, 2'b00, 1'b0, 32'h80000013, 32'h0, p, rd);
        chk("lbu_rdata", rd, 32'h00000080);
        do_d(1'b0, 2'b01, 1'b1, 32'h80000012, 32'h0, p, rd);
        chk("lh_hi_rdata", rd, 32'hFFFF80FF);
        do_d(1'b0, 2'b01, 1'b1, 32'h80000010, 32'h0, p, rd);
        chk("lh_lo_rdata", rd, 32'h00001234);
        do_d(1'b0, 2'b10, 1'b1, 32'h80000010, 32'h0, p, rd);
        chk("lw_rdata", rd, 32'h80FF1234);

        mem_word = 32'h11223344;
        r0 = rd_cnt; w0 = wr_cnt;
        do_d(1'b1, 2'b00, 1'b0, 32'h80000002, 32'h000000AB, p, rd);
        chk("sb_pulse", {28'h0, p}, 32'h2);
        chk("sb_reads", rd_cnt - r0, 1);
        chk("sb_writes", wr_cnt - w0, 1);
        chk("sb_wword", wr_word, 32'h11AB3344);
        chk("sb_maddr", last_addr, 32'h80000000);
        do_d(1'b1, 2'b01, 1'b0, 32'h80000002, 32'h0000BEEF, p, rd);
        chk("sh_wword", wr_word, 32'hBEEF3344);
        r0 = rd_cnt;
        do_d(1'b1, 2'b10, 1'b0, 32'h80000004, 32'hCAFEF00D, p, rd);
        chk("sw_pulse", {28'h0, p}, 32'h2);
        chk("sw_wword", wr_word, 32'hCAFEF00D);
        chk("sw_noread", rd_cnt - r0, 0);
        chk("sw_maddr", last_addr, 32'h80000004);

        rc0 = ren_cyc; wc0 = wen_cyc;
        do_d(1'b0, 2'b01, 1'b0, 32'h80000001, 32'h0, p, rd);
        chk("lh_mis_pulse", {28'h0, p}, 32'h1);
        @(negedge clk);
        chk("lh_mis_1cyc", {28'h0, if_done, if_err, d_done, d_err}, 32'h0);
        do_d(1'b0, 2'b11, 1'b0, 32'h80000000, 32'h0, p, rd);
        chk("size11_pulse", {28'h0, p}, 32'h1);
        do_f(32'hBFC00102, p, rd);
        chk("fetch_mis", {28'h0, p}, 32'h4);
        chk("mis_noaccess", ren_cyc - rc0 + wen_cyc - wc0, 0);

        ack_en = 1'b0;
        rc0 = ren_cyc;
        do_d(1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, p, rd);
        chk("to_pulse", {28'h0, p}, 32'h1);
        chk("to_ren_cyc", ren_cyc - rc0, 8);
        wc0 = wen_cyc;
        do_d(1'b1, 2'b00, 1'b0, 32'h80000001, 32'h0, p, rd);
        chk("to_rmw_pulse", {28'h0, p}, 32'h1);
        chk("to_rmw_nowr", wen_cyc - wc0, 0);

        if_addr = 32'hBFC00300; if_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ren) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_ren", {31'h0, seen}, 32'h1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_ren0", {31'h0, mem_ren}, 32'h0);
        chk("rst_mid_state", {25'h0, arb_state}, 32'h1);
        chk("rst_mid_pulses", {28'h0, if_done, if_err, d_done, d_err}, 32'h0);
        rst = 1'b0; ack_en = 1'b1;
        mem_word = 32'h24020001;
        do_f(32'hBFC00300, p, rd);
        chk("post_rst_pulse", {28'h0, p}, 32'h8);
        chk("post_rst_rdata", rd, 32'h24020001);

        mem_word = 32'h00000055;
        d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0;
        d_addr = 32'h80000010; if_addr = 32'hBFC00200;
        d_req = 1'b1; if_req = 1'b1;
        wait_pulse(40, p, rd, rd);
        chk("rr_first_d", {28'h0, p}, 32'h2);
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1;
        wait_pulse(40, p, rd, rd);
        chk("rr_second_f", {28'h0, p}, 32'h8);
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1;
        wait_pulse(40, p, rd, rd);
        chk("rr_third_d", {28'h0, p}, 32'h2);
        d_req = 1'b0;
        wait_pulse(40, p, rd, rd);
        chk("rr_fourth_f", {28'h0, p}, 32'h8);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_idle", {25'h0, arb_state}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
